// File: rtl/dsm_dac_pkg.sv
// rtl/dsm_dac_pkg.sv - shared parameters and width helpers for the DSM DAC front end
//
// Purpose: default sample width and rate-change factor, plus helpers that
// derive comb bit growth and the comb/modulator datapath width.
package dsm_dac_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_R     = 50;

    // Bit growth of an N-stage CIC with rate change R and differential delay M.
    function automatic int growth(input int r, input int m, input int n);
        return n * $clog2(r * m);
    endfunction

    // Comb output width for a single-stage, M=1 comb: input width plus growth
    // plus one sign bit of headroom so a full-scale swing cannot wrap.
    function automatic int cic_width(input int width, input int r);
        return width + growth(r, 1, 1) + 1;
    endfunction

endpackage

// File: rtl/dsm1_modulator.sv
// rtl/dsm1_modulator.sv - first-order delta-sigma modulator, one bit out per clock
//
// Purpose: converts a signed D-bit input to a 1-bit stream whose density of
// ones is the input expressed in offset binary divided by 2^D.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   dsm_in  - signed D-bit input, sampled every clock
//   dsm_out - registered carry-out of the accumulator (the bitstream)
module dsm1_modulator #(
    parameter int D = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [D-1:0] dsm_in,
    output logic         dsm_out
);

    logic [D-1:0] acc;
    logic [D-1:0] u;
    logic [D:0]   sum;

    // Flipping the sign bit maps two's complement onto 0..2^D-1, so the most
    // negative input never produces a carry and mid-scale carries every other cycle.
    always_comb begin
        u   = {~dsm_in[D-1], dsm_in[D-2:0]};
        sum = {1'b0, acc} + {1'b0, u};
    end

    // The carry out of the wrapping accumulator is the output bit; the
    // wrap itself is the modulation, so nothing saturates here.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            dsm_out <= 1'b0;
        end else begin
            acc     <= sum[D-1:0];
            dsm_out <= sum[D];
        end
    end

endmodule

// File: rtl/dsm_dac_comb_path.sv
// rtl/dsm_dac_comb_path.sv - strobe divider, single-stage comb and first-order DSM
//
// Purpose: front end of the DSM DAC transmit chain. Divides the clock down to
// a one-cycle sample strobe every R clocks, differentiates incoming samples at
// the strobe rate, and modulates the externally integrated signal to 1 bit at
// the full clock rate.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   in       - signed WIDTH-bit sample, used only on strobe edges
//   clk_en   - registered sample strobe, high one cycle in every R
//   comb_out - signed CIC_WIDTH-bit comb result to the external integrator
//   dsm_in   - signed CIC_WIDTH-bit integrator output, sampled every clock
//   dsm_out  - modulator bitstream for the DAC pin
module dsm_dac_comb_path
    import dsm_dac_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int R         = DEFAULT_R,
    parameter int GROWTH    = growth(R, 1, 1),
    parameter int CIC_WIDTH = WIDTH + GROWTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    output logic                 clk_en,
    output logic [CIC_WIDTH-1:0] comb_out,
    input  logic [CIC_WIDTH-1:0] dsm_in,
    output logic                 dsm_out
);

    localparam int CNT_W = (R > 1) ? $clog2(R) : 1;
    localparam int EXT   = CIC_WIDTH - WIDTH;

    logic [CNT_W-1:0]     cnt;
    logic                 cnt_wrap;
    logic [WIDTH-1:0]     dly;
    logic [CIC_WIDTH-1:0] in_ext;
    logic [CIC_WIDTH-1:0] dly_ext;

    assign cnt_wrap = (cnt == CNT_W'(R - 1));

    // Strobe divider. With R=1 the counter stays at 0 and wraps every edge,
    // which holds clk_en high continuously after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else begin
            cnt    <= cnt_wrap ? '0 : cnt + CNT_W'(1);
            clk_en <= cnt_wrap;
        end
    end

    // Sign-extend both operands so the difference of two full-scale samples
    // fits without wrapping.
    always_comb begin
        in_ext  = {{EXT{in[WIDTH-1]}}, in};
        dly_ext = {{EXT{dly[WIDTH-1]}}, dly};
    end

    // Comb runs on the strobe edge itself, so its result is visible the cycle
    // after clk_en reads high and the integrator picks it up on the next strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly      <= '0;
            comb_out <= '0;
        end else if (clk_en) begin
            comb_out <= in_ext - dly_ext;
            dly      <= in;
        end
    end

    dsm1_modulator #(
        .D (CIC_WIDTH)
    ) u_dsm1_modulator (
        .clk     (clk),
        .rst     (rst),
        .dsm_in  (dsm_in),
        .dsm_out (dsm_out)
    );

endmodule

// File: tb/tb_dsm_dac_comb_path.sv
// tb/tb_dsm_dac_comb_path.sv - scoreboard bench for dsm_dac_comb_path
module tb_dsm_dac_comb_path;

    localparam int WIDTH = 16;
    localparam int R     = 50;
    localparam int CW    = 23;
    localparam longint HALF = 64'sd1 <<< (CW - 1);

    typedef struct {
        bit     en;
        longint comb;
        bit     dout;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic [WIDTH-1:0]     in_s;
    logic                 clk_en;
    logic [CW-1:0]        comb_out;
    logic [CW-1:0]        dsm_in;
    logic                 dsm_out;

    int n_checks;
    int n_fail;

    exp_t exp_q[$];

    // Reference model state: edge count since release, last sampled sample,
    // running sum of offset-binary inputs (the bitstream is the increments of
    // floor(sum / 2^D)).
    int     m_edges;
    bit     m_en;
    longint m_prev;
    longint m_comb;
    longint m_sum;
    bit     m_dout;

    dsm_dac_comb_path dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_s),
        .clk_en   (clk_en),
        .comb_out (comb_out),
        .dsm_in   (dsm_in),
        .dsm_out  (dsm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Predicts DUT outputs after the next edge given the inputs on that edge.
    task automatic model_step(input bit r, input longint smp, input longint din);
        longint u;
        longint s_new;
        exp_t e;
        if (r) begin
            m_edges = 0;
            m_en    = 1'b0;
            m_prev  = 0;
            m_comb  = 0;
            m_sum   = 0;
            m_dout  = 1'b0;
        end else begin
            if (m_en) begin
                m_comb = smp - m_prev;
                m_prev = smp;
            end
            m_edges++;
            m_en   = (m_edges % R) == 0;
            u      = din + HALF;
            s_new  = m_sum + u;
            m_dout = ((s_new >>> CW) - (m_sum >>> CW)) != 0;
            m_sum  = s_new;
        end
        e.en   = m_en;
        e.comb = m_comb;
        e.dout = m_dout;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input longint smp, input longint din);
        rst    = r;
        in_s   = WIDTH'(smp);
        dsm_in = CW'(din);
        model_step(r, smp, din);
        @(negedge clk);
    endtask

    // Monitor: every cycle the DUT presents one output triple; pop and compare.
    initial begin
        exp_t e;
        longint comb_got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                comb_got = longint'($signed(comb_out));
                chk("clk_en", longint'(clk_en), longint'(e.en));
                chk("comb_out", comb_got, e.comb);
                chk("dsm_out", longint'(dsm_out), longint'(e.dout));
            end
        end
    end

    initial begin
        longint smp;
        longint din;
        n_checks = 0;
        n_fail   = 0;

        drive(1, 0, 0);
        drive(1, 0, 0);

        // Step 100 then -50, with mid-scale modulator input.
        for (int i = 0; i < 2 * R + 2; i++) drive(0, 100, 0);
        for (int i = 0; i < 2 * R; i++) drive(0, -50, 0);

        // Full-scale sample swing; modulator at both extremes.
        for (int i = 0; i < R; i++) drive(0, 32767, -HALF);
        for (int i = 0; i < R; i++) drive(0, -32768, -HALF);
        for (int i = 0; i < 1000; i++) drive(0, 0, -HALF);
        for (int i = 0; i < 1000; i++) drive(0, 0, HALF - 1);

        // Reset for one cycle when the divider count reaches 25.
        while ((m_edges % R) != 25) drive(0, 7, 12345);
        drive(1, 7, 12345);
        for (int i = 0; i < R + 5; i++) drive(0, 9, 0);

        // Random samples and modulator input, with occasional extremes.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0:       smp = 32767;
                1:       smp = -32768;
                default: smp = longint'($urandom_range(0, 65535)) - 32768;
            endcase
            case ($urandom_range(0, 7))
                0:       din = -HALF;
                1:       din = HALF - 1;
                default: din = longint'($urandom_range(0, 8388607)) - HALF;
            endcase
            drive(0, smp, din);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsm_dac_comb_path.md
# dsm_dac_comb_path

Front end of the DSM DAC transmit chain. It generates the decimated sample strobe, applies a single-stage comb (M=1) to incoming signed samples at the strobe rate, and runs a first-order delta-sigma modulator at the full clock rate on the integrated signal returned from the external integrator. Its output is the 1-bit stream that drives the DAC pin.

## Interface
- `WIDTH`, 16: signed input sample width.
- `R`, 50: rate-change factor and strobe divide ratio; must be ≥ 1.
- `GROWTH`, $clog2(R) = 6: comb bit growth (N=1, M=1).
- `CIC_WIDTH`, WIDTH+GROWTH+1 = 23: comb output width and DSM input width.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock (100 MHz nominal).
- `rst` input 1: synchronous, active-high reset.
- `in` input WIDTH: signed two's-complement sample; sampled only when `clk_en` = 1.
- `clk_en` output 1: sample strobe; one-cycle pulse every R clocks.
- `comb_out` output CIC_WIDTH: signed comb result, sent to the external integrator.
- `dsm_in` input CIC_WIDTH: signed integrator output; sampled every clock.
- `dsm_out` output 1: modulator bitstream.

## Operation
- Strobe divider: counter `cnt` runs 0..R-1 and wraps to 0.
  - `clk_en` is registered and is set to 1 on the edge where `cnt` wraps from R-1 to 0; otherwise it is 0.
  - With R = 1, `clk_en` is held at 1 on every cycle after reset.
- Comb: on each edge with `clk_en` = 1:
  - `comb_out <= sext(in) - sext(dly)`, then `dly <= in`.
  - `sext` sign-extends to CIC_WIDTH; the difference cannot overflow.
  - `comb_out` and `dly` hold their values when `clk_en` = 0.
- Modulator, with D = CIC_WIDTH, evaluated every clock:
  - `u = {~dsm_in[D-1], dsm_in[D-2:0]}` converts the input to offset binary.
  - `sum = {1'b0, acc} + u` (D+1 bits).
  - `acc <= sum[D-1:0]` and `dsm_out <= sum[D]`.
  - The density of ones equals u / 2^D:
    - `dsm_in` = 0 gives 1/2.
    - Most-negative input gives all zeros.
    - Most-positive input gives (2^D - 1)/2^D.

## Timing
- Reset values: `cnt` = 0, `clk_en` = 0, `dly` = 0, `comb_out` = 0, `acc` = 0, `dsm_out` = 0.
- Reset asserted mid-operation clears all state on the next edge. The first `clk_en` after release arrives exactly R edges later.
- `clk_en` period is exactly R cycles, high for 1 cycle.
- Comb latency: `comb_out` updates on the strobe edge itself and is visible in the cycle where `clk_en` reads 1 plus one. Downstream registers therefore use the next strobe.
- DSM latency: 1 clock from `dsm_in` to its effect on `dsm_out`. The DSM ignores `clk_en`.
- Accumulator wrap (carry out) is the modulator action; no saturation anywhere.
- `in` changing between strobes has no effect.

## Structure
- Package `dsm_dac_pkg`:
  - default WIDTH and R;
  - function `growth(R, M, N) = N*$clog2(R*M)`;
  - `cic_width` helper.
- One natural sub-module, `dsm1_modulator` (parameter D; ports `clk`, `rst`, `dsm_in`, `dsm_out`), reusable for the second-order variant comparison.
- Divider and comb stay inline in the top.

## Test plan
- Reset then free-run with R=50: first `clk_en` on edge 50 after `rst` drops, then on every 50th edge, each exactly 1 cycle wide.
- Comb step:
  - `in` = 100 constant: `comb_out` = 100 after first strobe, 0 after second.
  - Then `in` = -50: `comb_out` = -150, then 0.
- Comb extremes: `in` = -32768 after 32767 gives `comb_out` = -65535 in 23 bits, no wrap.
- DSM mid-scale: `dsm_in` = 0 after reset gives `dsm_out` = 0,1,0,1,… starting in the first cycle.
- DSM full scale:
  - `dsm_in` = -2^22 gives `dsm_out` = 0 for 1000 cycles.
  - `dsm_in` = 2^22-1 gives ones density ≥ 0.999 over 1000 cycles.
- Reset mid-run: assert `rst` for 1 cycle at count 25. The next cycle shows all outputs 0, and the next `clk_en` arrives 50 edges after release.
